// File: rtl/exp_golomb_pkg.sv
// Shared state type and arithmetic helpers for the order-k Exp-Golomb encoder.
package exp_golomb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        SUFFIX = 2'd2
    } eg_state_e;

    // Wide enough for any practical DATA_W; callers truncate the result.
    localparam int MAP_W = 34;

    // se mapping: x>0 -> 2x-1, x<=0 -> -2x (the most negative input maps to 2^DATA_W).
    function automatic logic [MAP_W-1:0] se_map(input logic signed [MAP_W-1:0] x);
        logic [MAP_W-1:0] ux;
        ux = x;
        if (!x[MAP_W-1] && (ux != '0)) begin
            return (ux << 1) - MAP_W'(1);
        end
        return (MAP_W'(0) - ux) << 1;
    endfunction

    function automatic logic [7:0] eg_len(input logic [7:0] n, input logic [7:0] k);
        return (n << 1) - k + 8'd1;
    endfunction

endpackage

// File: rtl/eg_lzd.sv
// Combinational leading-one detector: returns the index of the highest set bit.
module eg_lzd #(
    parameter int W     = 10,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exp_golomb_enc_k.sv
// Order-k Exp-Golomb serial encoder: ue/se values in, codeword out MSB-first,
// one bit per valid/ready beat.
module exp_golomb_enc_k
    import exp_golomb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K_MAX  = 3,
    parameter int K_W    = $clog2(K_MAX + 1),
    parameter int LEN_W  = $clog2(2 * DATA_W + 4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [K_W-1:0]    in_k,
    input  logic              in_signed,
    output logic              bit_valid,
    output logic              bit_data,
    output logic              bit_last,
    input  logic              bit_ready,
    output logic [LEN_W-1:0]  code_len,
    output logic              busy,
    output eg_state_e         dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready;
    // a presented bit (bit_data/bit_last/code_len) holds until it transfers.

    localparam int W_W = DATA_W + 2;
    localparam int N_W = $clog2(W_W);

    eg_state_e        state_q, state_d;
    logic [W_W-1:0]   w_q, w_d;
    logic [N_W-1:0]   pcnt_q, pcnt_d;
    logic [N_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [K_W-1:0]   keff;
    logic [DATA_W:0]  m;
    logic [W_W-1:0]   w_in;
    logic [N_W-1:0]   n_in;
    logic [N_W-1:0]   p_in;

    always_comb begin
        keff = (in_k > K_W'(K_MAX)) ? K_W'(K_MAX) : in_k;
        if (in_signed) begin
            m = (DATA_W + 1)'(se_map(MAP_W'(signed'(in_data))));
        end else begin
            m = {1'b0, in_data};
        end
        w_in = {1'b0, m} + (W_W'(1) << keff);
        // w_in >= 2^keff, so the leading-one index never falls below keff.
        p_in = n_in - N_W'(keff);
    end

    eg_lzd #(
        .W     (W_W),
        .IDX_W (N_W)
    ) u_lzd (
        .vec_i (w_in),
        .idx_o (n_in)
    );

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        pcnt_d    = pcnt_q;
        idx_d     = idx_q;
        len_d     = len_q;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        bit_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_d     = w_in;
                    pcnt_d  = p_in;
                    idx_d   = n_in;
                    len_d   = LEN_W'(eg_len(8'(n_in), 8'(keff)));
                    state_d = (p_in != '0) ? PREFIX : SUFFIX;
                end
            end
            PREFIX: begin
                bit_valid = 1'b1;
                if (bit_ready) begin
                    pcnt_d = pcnt_q - N_W'(1);
                    if (pcnt_q == N_W'(1)) begin
                        state_d = SUFFIX;
                    end
                end
            end
            SUFFIX: begin
                bit_valid = 1'b1;
                bit_data  = w_q[idx_q];
                bit_last  = (idx_q == '0);
                if (bit_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                        len_d   = '0;
                    end else begin
                        idx_d = idx_q - N_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            pcnt_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    assign code_len  = len_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exp_golomb_enc_k.sv
// Self-checking bench for exp_golomb_enc_k: directed vectors plus randomized
// traffic with random backpressure, checked against an arithmetic model.
module tb_exp_golomb_enc_k;
    import exp_golomb_pkg::*;

    localparam int DATA_W = 8;
    localparam int K_MAX  = 3;
    localparam int K_W    = 3;
    localparam int LEN_W  = $clog2(2 * DATA_W + 4);
    localparam int ENT_W  = LEN_W + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [K_W-1:0]    in_k = '0;
    logic              in_signed = 1'b0;
    logic              bit_valid;
    logic              bit_data;
    logic              bit_last;
    logic              bit_ready = 1'b1;
    logic [LEN_W-1:0]  code_len;
    logic              busy;
    eg_state_e         dbg_state;

    int checks = 0;
    int errors = 0;
    // Entry layout: {code_len, last, data}
    logic [ENT_W-1:0] exp_q[$];
    bit rdy_rand = 1'b0;

    exp_golomb_enc_k #(
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX),
        .K_W    (K_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .in_signed (in_signed),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_last  (bit_last),
        .bit_ready (bit_ready),
        .code_len  (code_len),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the Exp-Golomb definition.
    task automatic push_model(input logic [DATA_W-1:0] d, input int k, input bit s);
        longint x, m, w;
        int n, keff, len;
        logic b;
        keff = (k > K_MAX) ? K_MAX : k;
        if (s) begin
            x = longint'($signed(d));
            m = (x > 0) ? 2 * x - 1 : -2 * x;
        end else begin
            m = longint'(d);
        end
        w = m + (longint'(1) << keff);
        n = 0;
        while ((w >> (n + 1)) != 0) n++;
        len = 2 * n - keff + 1;
        for (int i = 0; i < n - keff; i++) exp_q.push_back({LEN_W'(len), 1'b0, 1'b0});
        for (int i = n; i >= 0; i--) begin
            b = 1'((w >> i) & 1);
            exp_q.push_back({LEN_W'(len), (i == 0), b});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DATA_W-1:0] d, input int k, input bit s);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
            return;
        end
        push_model(d, k, s);
        in_data   = d;
        in_k      = K_W'(k);
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = DATA_W'($urandom);
        in_k      = K_W'($urandom);
        in_signed = 1'($urandom);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic directed(input string name, input logic [DATA_W-1:0] d, input int k,
                            input bit s, input int exp_len);
        int c;
        send(d, k, s);
        chk({name, "_code_len"}, 32'(code_len), 32'(exp_len));
        wait_idle(c);
        chk({name, "_cycles"}, 32'(c), 32'(exp_len));
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) bit_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: data=%0b last=%0b len=%0d with empty queue",
                             bit_data, bit_last, code_len);
                end else begin
                    chk("bit_beat", 32'({code_len, bit_last, bit_data}), 32'(exp_q[0]));
                    chk("busy_active", 32'(busy), 32'(1));
                    if (bit_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_code_len", 32'(code_len), 32'(0));
                chk("idle_in_ready", 32'(in_ready), 32'(1));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_bit_valid", 32'(bit_valid), 32'(0));
        chk("rst_bit_data", 32'(bit_data), 32'(0));
        chk("rst_bit_last", 32'(bit_last), 32'(0));
        chk("rst_code_len", 32'(code_len), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("ue_k0_0",     8'd0,   0, 1'b0, 1);
        directed("ue_k0_3",     8'd3,   0, 1'b0, 5);
        directed("ue_k0_255",   8'd255, 0, 1'b0, 17);
        directed("ue_k1_3",     8'd3,   1, 1'b0, 4);
        directed("ue_k3_0",     8'd0,   3, 1'b0, 4);
        directed("ue_clamp_0",  8'd0,   5, 1'b0, 4);
        directed("ue_clamp_200", 8'd200, 7, 1'b0, 12);
        directed("ue_k3_255",   8'd255, 3, 1'b0, 14);
        directed("se_k0_m2",    8'hFE,  0, 1'b1, 5);
        directed("se_k0_p1",    8'h01,  0, 1'b1, 3);
        directed("se_k0_min",   8'h80,  0, 1'b1, 17);
        directed("se_k0_max",   8'h7F,  0, 1'b1, 15);
        directed("se_k2_0",     8'h00,  2, 1'b1, 3);

        // Backpressure: stall the second bit of ue(3) for three cycles.
        send(8'd3, 0, 1'b0);
        @(posedge clk); #1;
        bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_state_held", 32'(dbg_state), 32'(PREFIX));
        chk("bp_valid_held", 32'(bit_valid), 32'(1));
        bit_ready = 1'b1;
        wait_idle(c);

        // Reset in the middle of a 17-bit codeword.
        send(8'd255, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("mid_rst_bit_valid", 32'(bit_valid), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        chk("mid_rst_code_len", 32'(code_len), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(bit_valid), 32'(0));
        directed("post_rst_ue3", 8'd3, 0, 1'b0, 5);

        // Randomized traffic with random sink backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(DATA_W'($urandom), $urandom_range(0, 7), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle(c);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle(c);
        rdy_rand = 1'b0;
        bit_ready = 1'b1;
        wait_idle(c);
        chk("random_drained_idle", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exp_golomb_enc_k.md
Name: exp_golomb_enc_k

Overview:
Parametrised, order-k Exponential-Golomb serial encoder. It is the successor to the fixed k = 0, 8-bit encoder.
- Accepts one value per handshake, in unsigned (ue) or signed (se) mode, with a run-time selectable order k.
- Emits the codeword MSB-first, one bit per beat, on a valid/ready bit stream.
- Sits between a symbol source and a bit-packer, which may apply backpressure.

Parameters:
DATA_W, 8, width of input value.
K_MAX, 3, largest supported Golomb order k; requested k above this is clamped.
K_W, $clog2(K_MAX+1), width of in_k.
LEN_W, $clog2(2*DATA_W+4), width of code_len; covers the maximum codeword length.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  input value present.
in_ready  out  1  encoder can accept a value; high only in IDLE.
in_data  in  DATA_W  value; two's complement when in_signed=1.
in_k  in  K_W  Golomb order for this value, sampled at accept.
in_signed  in  1  1 = se mapping, 0 = ue, sampled at accept.
bit_valid  out  1  bit_data is valid.
bit_data  out  1  current codeword bit.
bit_last  out  1  current bit is the final bit of the codeword.
bit_ready  in  1  sink consumes the bit when bit_valid & bit_ready.
code_len  out  LEN_W  total length of the current codeword, held while busy; 0 in IDLE.
busy  out  1  codeword in flight (state != IDLE).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, in_ready=1, bit_valid=0, bit_data=0, bit_last=0, code_len=0, busy=0.
  - Reset mid-codeword discards the remaining bits. No further bit_valid appears.
- Accept occurs on in_valid & in_ready at a clk edge. The following are latched:
  - keff = min(in_k, K_MAX).
  - m = in_signed ? (x>0 ? 2x-1 : -2x) : in_data. Width DATA_W+1, no overflow; x = -2^(DATA_W-1) maps to 2^DATA_W.
  - w = m + 2^keff. Width DATA_W+2.
  - N = index of the leading one of w.
  - prefix count P = N-keff.
  - code_len = 2N-keff+1.
- Codeword = P zeros, then the N+1 bits of w MSB-first (the leading bit is always 1).
- FSM states IDLE, PREFIX, SUFFIX:
  - IDLE -> PREFIX on accept if P>0; otherwise IDLE -> SUFFIX.
  - PREFIX: bit_data=0. A down-counter decrements on each bit handshake. At the handshake of the last zero -> SUFFIX.
  - SUFFIX: bit_data = w[idx], idx starting at N and decrementing per handshake. bit_last=1 when idx=0. Handshake with idx=0 -> IDLE.
- Latency and throughput:
  - First bit_valid appears the cycle after accept.
  - bit_valid stays 1 continuously through PREFIX and SUFFIX.
  - After the last handshake, in_ready=1 in the next cycle. Throughput is one codeword per code_len+1 cycles with no backpressure.
- Backpressure: while bit_valid & !bit_ready, the values of bit_data, bit_last, code_len and all state hold stable.
- in_data, in_k and in_signed are ignored outside the accept cycle. in_valid while busy has no effect.

Decomposition:
- Package exp_golomb_pkg holds:
  - state enum eg_state_e {IDLE, PREFIX, SUFFIX};
  - function se_map(x) for the signed mapping;
  - function eg_len(N, k) for the codeword length.
- One sub-module, eg_lzd: a parametrised leading-one detector over DATA_W+2 bits that returns N. It is combinational and used at accept.

Test Plan:
- ue, k=0, in_data=0 -> single bit "1", bit_last=1 on the first beat, code_len=1. in_ready=1 two cycles after accept.
- ue, k=0, in_data=3 -> bits 0,0,1,0,0, code_len=5.
- ue, k=0, in_data=255 -> 8 zeros then 1 followed by 8 zeros, code_len=17.
- ue, k=1, in_data=3 -> bits 0,1,0,1, code_len=4.
- ue, k=3, in_data=0 -> bits 1,0,0,0, code_len=4 (no prefix).
- ue, in_k=3 with K_MAX=2 -> encoded with k=2.
- se, k=0, in_data=8'hFE (-2) -> mapped to 4 -> bits 0,0,1,0,1.
- se, k=0, in_data=8'h01 -> mapped to 1 -> bits 0,1,0.
- ue, k=0, in_data=3, with bit_ready=0 for 3 cycles after the 2nd bit -> that bit is held stable, and the sequence completes unchanged.
- rst_n=0 after the 3rd bit of a 17-bit code -> next edge gives bit_valid=0, in_ready=1, code_len=0. A following accept encodes correctly.
